// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: object descriptor,
// shape encoding, background colour constants and a small distance helper.
package sprite_pkg;

   // Widths the object descriptor is built from; the top-level defaults follow these.
   localparam int PKG_COORD_W = 10;
   localparam int PKG_COLOR_W = 8;

   typedef enum logic {
      SHP_SQUARE = 1'b0,
      SHP_CIRCLE = 1'b1
   } shape_e;

   typedef struct packed {
      logic                     en;
      shape_e                   shape;
      logic [PKG_COORD_W-1:0]   x;
      logic [PKG_COORD_W-1:0]   y;
      logic [PKG_COORD_W-1:0]   size;
      logic [3*PKG_COLOR_W-1:0] rgb;
   } obj_t;

   localparam logic [7:0] BG_RED       = 8'h3F;
   localparam logic [7:0] BG_GREEN     = 8'h00;
   localparam logic [7:0] BG_BLUE_BASE = 8'h3F;

   // |a - b| computed one bit wider than the coordinates so an object hanging
   // off either screen edge never aliases back onto the visible area.
   function automatic logic [PKG_COORD_W:0] abs_diff(input logic [PKG_COORD_W-1:0] a,
                                                     input logic [PKG_COORD_W-1:0] b);
      logic signed [PKG_COORD_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[PKG_COORD_W] ? $unsigned(-d) : $unsigned(d);
   endfunction

endpackage

// File: rtl/obj_hit_test.sv
// Per-object hit tester: first two pipeline stages for one object.
// Stage 1 registers the distance magnitudes, stage 2 registers the hit bit.
// The object's enable, shape and colour travel alongside the pixel so a
// shadow-register swap in mid-flight cannot mix old and new object state.
module obj_hit_test
   import sprite_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  obj_t                     obj,
   input  logic [PKG_COORD_W-1:0]   draw_x,
   input  logic [PKG_COORD_W-1:0]   draw_y,
   output logic                     hit,
   output logic [3*PKG_COLOR_W-1:0] rgb
);

   localparam int W  = PKG_COORD_W;
   localparam int PW = 2*W + 3;

   logic [W:0]               abs_dx_d;
   logic [W:0]               abs_dy_d;
   logic [W-1:0]             size_d;
   logic                     en_d;
   shape_e                   shape_d;
   logic [3*PKG_COLOR_W-1:0] rgb_d;

   logic [PW-1:0]            dx_sq;
   logic [PW-1:0]            dy_sq;
   logic [PW-1:0]            size_sq;
   logic                     circle_in;
   logic                     square_in;

   // Stage 1: capture distance magnitudes plus the object state this pixel sees.
   always_ff @(posedge clk) begin
      if (reset) begin
         abs_dx_d <= '0;
         abs_dy_d <= '0;
         size_d   <= '0;
         en_d     <= 1'b0;
         shape_d  <= SHP_SQUARE;
         rgb_d    <= '0;
      end else begin
         abs_dx_d <= abs_diff(draw_x, obj.x);
         abs_dy_d <= abs_diff(draw_y, obj.y);
         size_d   <= obj.size;
         en_d     <= obj.en;
         shape_d  <= obj.shape;
         rgb_d    <= obj.rgb;
      end
   end

   // Stage 2 geometry: both shape tests in parallel, wide enough that squares never overflow.
   always_comb begin
      dx_sq     = PW'(abs_dx_d) * PW'(abs_dx_d);
      dy_sq     = PW'(abs_dy_d) * PW'(abs_dy_d);
      size_sq   = PW'(size_d) * PW'(size_d);
      circle_in = (dx_sq + dy_sq) <= size_sq;
      square_in = (abs_dx_d <= {1'b0, size_d}) && (abs_dy_d <= {1'b0, size_d});
   end

   // Stage 2 register: a disabled object never reports a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit <= 1'b0;
         rgb <= '0;
      end else begin
         hit <= en_d && ((shape_d == SHP_CIRCLE) ? circle_in : square_in);
         rgb <= rgb_d;
      end
   end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined multi-object pixel colouriser between the VGA controller and the DAC.
// Holds the double-buffered object state, the per-object hit testers, the
// valid/gradient delay line and the final priority mux with background gradient.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int N_OBJ   = 4,
   parameter int COORD_W = PKG_COORD_W,
   parameter int COLOR_W = PKG_COLOR_W,
   parameter int GRAD_SH = 3,
   localparam int ID_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
)(
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_start,
   input  logic [N_OBJ-1:0]           obj_en,
   input  logic [N_OBJ-1:0]           obj_shape,
   input  logic [N_OBJ*COORD_W-1:0]   obj_x,
   input  logic [N_OBJ*COORD_W-1:0]   obj_y,
   input  logic [N_OBJ*COORD_W-1:0]   obj_size,
   input  logic [N_OBJ*3*COLOR_W-1:0] obj_rgb,
   input  logic                       pix_valid,
   input  logic [COORD_W-1:0]         DrawX,
   input  logic [COORD_W-1:0]         DrawY,
   output logic [COLOR_W-1:0]         Red,
   output logic [COLOR_W-1:0]         Green,
   output logic [COLOR_W-1:0]         Blue,
   output logic                       pix_valid_o,
   output logic                       hit,
   output logic [ID_W-1:0]            hit_id
);

   localparam int GRAD_W = COORD_W - GRAD_SH;

   obj_t                 shadow [N_OBJ];
   logic [N_OBJ-1:0]     hit_vec;
   logic [3*COLOR_W-1:0] obj_rgb_d2 [N_OBJ];

   logic                 valid_d1;
   logic                 valid_d2;
   logic [GRAD_W-1:0]    grad_d1;
   logic [GRAD_W-1:0]    grad_d2;

   logic                 any_hit;
   logic [ID_W-1:0]      win_id;
   logic [3*COLOR_W-1:0] win_rgb;
   logic [COLOR_W-1:0]   bg_blue;

   // Shadow object set: swapped only on frame_start so a frame never tears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < N_OBJ; k++) begin
            shadow[k] <= '0;
         end
      end else if (frame_start) begin
         for (int k = 0; k < N_OBJ; k++) begin
            shadow[k].en    <= obj_en[k];
            shadow[k].shape <= shape_e'(obj_shape[k]);
            shadow[k].x     <= obj_x[k*COORD_W +: COORD_W];
            shadow[k].y     <= obj_y[k*COORD_W +: COORD_W];
            shadow[k].size  <= obj_size[k*COORD_W +: COORD_W];
            shadow[k].rgb   <= obj_rgb[k*3*COLOR_W +: 3*COLOR_W];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_OBJ; g++) begin : g_obj
         obj_hit_test u_hit (
            .clk    (Clk),
            .reset  (Reset),
            .obj    (shadow[g]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_vec[g]),
            .rgb    (obj_rgb_d2[g])
         );
      end
   endgenerate

   // Delay line for pixel valid and the gradient slice of DrawX, matched to the hit testers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_d1 <= 1'b0;
         valid_d2 <= 1'b0;
         grad_d1  <= '0;
         grad_d2  <= '0;
      end else begin
         valid_d1 <= pix_valid;
         valid_d2 <= valid_d1;
         grad_d1  <= DrawX[COORD_W-1:GRAD_SH];
         grad_d2  <= grad_d1;
      end
   end

   // Priority encoder: scanning downward lets the lowest hitting index win.
   always_comb begin
      any_hit = 1'b0;
      win_id  = '0;
      win_rgb = '0;
      for (int k = N_OBJ-1; k >= 0; k--) begin
         if (hit_vec[k]) begin
            any_hit = 1'b1;
            win_id  = ID_W'(k);
            win_rgb = obj_rgb_d2[k];
         end
      end
   end

   // Background blue ramp darkens left to right and wraps modulo the channel width.
   always_comb begin
      bg_blue = COLOR_W'(BG_BLUE_BASE) - COLOR_W'(grad_d2);
   end

   // Stage 3 output register: object colour on a hit, background otherwise.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Red         <= '0;
         Green       <= '0;
         Blue        <= '0;
         pix_valid_o <= 1'b0;
         hit         <= 1'b0;
         hit_id      <= '0;
      end else begin
         pix_valid_o <= valid_d2;
         hit         <= any_hit;
         hit_id      <= win_id;
         if (any_hit) begin
            Red   <= win_rgb[3*COLOR_W-1 -: COLOR_W];
            Green <= win_rgb[2*COLOR_W-1 -: COLOR_W];
            Blue  <= win_rgb[COLOR_W-1:0];
         end else begin
            Red   <= COLOR_W'(BG_RED);
            Green <= COLOR_W'(BG_GREEN);
            Blue  <= bg_blue;
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels push their expected
// colour into a queue, an independent monitor pops and compares on pix_valid_o.
module tb_sprite_compositor;

   localparam int N_OBJ   = 4;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 8;

   logic                       Clk = 1'b0;
   logic                       Reset = 1'b1;
   logic                       frame_start = 1'b0;
   logic [N_OBJ-1:0]           obj_en = '0;
   logic [N_OBJ-1:0]           obj_shape = '0;
   logic [N_OBJ*COORD_W-1:0]   obj_x = '0;
   logic [N_OBJ*COORD_W-1:0]   obj_y = '0;
   logic [N_OBJ*COORD_W-1:0]   obj_size = '0;
   logic [N_OBJ*3*COLOR_W-1:0] obj_rgb = '0;
   logic                       pix_valid = 1'b0;
   logic [COORD_W-1:0]         DrawX = '0;
   logic [COORD_W-1:0]         DrawY = '0;
   logic [COLOR_W-1:0]         Red;
   logic [COLOR_W-1:0]         Green;
   logic [COLOR_W-1:0]         Blue;
   logic                       pix_valid_o;
   logic                       hit;
   logic [1:0]                 hit_id;

   typedef struct {
      string       name;
      logic        hit;
      logic [1:0]  id;
      logic [23:0] rgb;
      int          due;
   } exp_t;

   exp_t expq[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   sprite_compositor #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .GRAD_SH(3)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .obj_en      (obj_en),
      .obj_shape   (obj_shape),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
      .obj_size    (obj_size),
      .obj_rgb     (obj_rgb),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .pix_valid_o (pix_valid_o),
      .hit         (hit),
      .hit_id      (hit_id)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Background colour: R=3F, G=00, B=3F-(x>>3) wrapped to 8 bits.
   function automatic logic [23:0] bg(input int x);
      logic [7:0] b;
      b = 8'h3F - 8'(x >> 3);
      return {8'h3F, 8'h00, b};
   endfunction

   task automatic setObj(input int k, input logic en, input logic shape, input int x, input int y,
                         input int size, input logic [23:0] rgb);
      obj_en[k]                = en;
      obj_shape[k]             = shape;
      obj_x[k*COORD_W +: COORD_W]    = x[COORD_W-1:0];
      obj_y[k*COORD_W +: COORD_W]    = y[COORD_W-1:0];
      obj_size[k*COORD_W +: COORD_W] = size[COORD_W-1:0];
      obj_rgb[k*24 +: 24]      = rgb;
   endtask

   task automatic applyStimulus(input string name, input int x, input int y, input logic fs,
                                input logic exp_hit, input logic [1:0] exp_id,
                                input logic [23:0] exp_rgb, input logic push);
      exp_t e;
      @(negedge Clk);
      DrawX       = x[COORD_W-1:0];
      DrawY       = y[COORD_W-1:0];
      pix_valid   = 1'b1;
      frame_start = fs;
      if (push) begin
         e.name = name;
         e.hit  = exp_hit;
         e.id   = exp_id;
         e.rgb  = exp_rgb;
         e.due  = cyc + 3;
         expq.push_back(e);
      end
   endtask

   task automatic hitPx(input string name, input int x, input int y, input logic [1:0] id,
                        input logic [23:0] rgb);
      applyStimulus(name, x, y, 1'b0, 1'b1, id, rgb, 1'b1);
   endtask

   task automatic missPx(input string name, input int x, input int y);
      applyStimulus(name, x, y, 1'b0, 1'b0, 2'd0, bg(x), 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         pix_valid   = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic pulseFrame();
      @(negedge Clk);
      pix_valid   = 1'b0;
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
   endtask

   task automatic checkZero(input string name);
      checkOutput({name, " pix_valid_o"}, 32'(pix_valid_o), 32'd0);
      checkOutput({name, " hit"},         32'(hit),         32'd0);
      checkOutput({name, " hit_id"},      32'(hit_id),      32'd0);
      checkOutput({name, " rgb"},         32'({Red, Green, Blue}), 32'd0);
   endtask

   // Monitor: every valid output pixel must match the oldest queued expectation on time.
   always @(posedge Clk) begin
      exp_t e;
      #1;
      if (!Reset && pix_valid_o === 1'b1) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected pixel queue_depth", 32'd0, 32'd1);
         end else begin
            e = expq.pop_front();
            checkOutput({e.name, " hit"},     32'(hit),              32'(e.hit));
            checkOutput({e.name, " hit_id"},  32'(hit_id),           32'(e.id));
            checkOutput({e.name, " rgb"},     32'({Red, Green, Blue}), 32'(e.rgb));
            checkOutput({e.name, " latency"}, 32'(cyc),              32'(e.due));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge Clk);
      checkZero("reset");
      Reset = 1'b0;

      // 1: nothing loaded yet, (100,100) is background with B = 3F - 12 = 33
      applyStimulus("t1 bg", 100, 100, 1'b0, 1'b0, 2'd0, 24'h3F0033, 1'b1);
      applyStimulus("t1 bg639", 639, 100, 1'b0, 1'b0, 2'd0, 24'h3F00F0, 1'b1);

      // 2: circle r=10 at (320,240), sweep row 240
      setObj(0, 1'b1, 1'b1, 320, 240, 10, 24'hFF0000);
      pulseFrame();
      for (int x = 308; x <= 332; x++) begin
         if (x >= 310 && x <= 330) hitPx("t2 row", x, 240, 2'd0, 24'hFF0000);
         else                      missPx("t2 row", x, 240);
      end
      hitPx("t2 diag in", 327, 247, 2'd0, 24'hFF0000);
      missPx("t2 diag out", 328, 247);

      // 3: square half-side 5 at (50,50)
      setObj(0, 1'b1, 1'b0, 50, 50, 5, 24'h00FF00);
      pulseFrame();
      hitPx("t3 sq corner", 55, 55, 2'd0, 24'h00FF00);
      applyStimulus("t3 sq edge", 56, 50, 1'b0, 1'b0, 2'd0, 24'h3F0038, 1'b1);
      setObj(0, 1'b1, 1'b1, 50, 50, 5, 24'h00FF00);
      pulseFrame();
      applyStimulus("t3 circ corner", 55, 55, 1'b0, 1'b0, 2'd0, 24'h3F0039, 1'b1);
      // size 0 covers only the centre for both shapes
      setObj(0, 1'b1, 1'b0, 50, 50, 0, 24'h123456);
      setObj(1, 1'b1, 1'b1, 80, 50, 0, 24'h654321);
      pulseFrame();
      hitPx("t3 sq0 centre", 50, 50, 2'd0, 24'h123456);
      missPx("t3 sq0 next", 51, 50);
      hitPx("t3 circ0 centre", 80, 50, 2'd1, 24'h654321);
      missPx("t3 circ0 next", 80, 51);
      // off-screen object near the right edge must not wrap onto x=0
      setObj(1, 1'b1, 1'b0, 1015, 100, 20, 24'h0F0F0F);
      pulseFrame();
      missPx("t3 clip wrap", 0, 100);
      hitPx("t3 clip in", 1000, 100, 2'd1, 24'h0F0F0F);
      setObj(1, 1'b0, 1'b0, 0, 0, 0, 24'h0);

      // 4: overlap priority, disabled object with matching geometry
      setObj(0, 1'b1, 1'b1, 200, 200, 8, 24'h112233);
      setObj(1, 1'b0, 1'b0, 200, 200, 8, 24'h445566);
      setObj(2, 1'b1, 1'b0, 200, 200, 8, 24'hAABBCC);
      pulseFrame();
      hitPx("t4 overlap", 200, 200, 2'd0, 24'h112233);
      hitPx("t4 circ in", 205, 205, 2'd0, 24'h112233);
      hitPx("t4 sq only", 207, 207, 2'd2, 24'hAABBCC);
      setObj(0, 1'b0, 1'b1, 200, 200, 8, 24'h112233);
      pulseFrame();
      hitPx("t4 obj0 off", 200, 200, 2'd2, 24'hAABBCC);

      // 5: shadow registers isolate mid-frame changes
      setObj(0, 1'b1, 1'b1, 300, 100, 3, 24'h0000FF);
      pulseFrame();
      hitPx("t5 base", 300, 100, 2'd0, 24'h0000FF);
      setObj(0, 1'b1, 1'b1, 400, 100, 3, 24'h0000FF);
      hitPx("t5 no fs old", 300, 100, 2'd0, 24'h0000FF);
      applyStimulus("t5 no fs new", 400, 100, 1'b0, 1'b0, 2'd0, 24'h3F000D, 1'b1);
      applyStimulus("t5 fs pixel", 300, 100, 1'b1, 1'b1, 2'd0, 24'h0000FF, 1'b1);
      applyStimulus("t5 after fs old", 300, 100, 1'b0, 1'b0, 2'd0, 24'h3F001A, 1'b1);
      hitPx("t5 after fs new", 400, 100, 2'd0, 24'h0000FF);

      // 6: reset with the pipeline full; first pixel emerges, the other two are flushed
      hitPx("t6 first", 400, 100, 2'd0, 24'h0000FF);
      applyStimulus("t6 flushed", 400, 100, 1'b0, 1'b1, 2'd0, 24'h0000FF, 1'b0);
      applyStimulus("t6 flushed", 400, 100, 1'b0, 1'b1, 2'd0, 24'h0000FF, 1'b0);
      @(negedge Clk);
      Reset     = 1'b1;
      pix_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         checkZero("t6 in reset");
      end
      Reset = 1'b0;
      idle(4);
      applyStimulus("t6 shadow cleared", 400, 100, 1'b0, 1'b0, 2'd0, 24'h3F000D, 1'b1);

      idle(6);
      checkOutput("drain queue_depth", 32'(expq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
